// File: rtl/adc_capture_seq_if.sv
// AXIS beat of SAMP_PER_CLK complex samples ({im,re} per SAMP_W slot).
// tuser[0] flags the first beat of a capture, tlast the frame end.
interface adc_capture_seq_if #(
  parameter int SAMP_PER_CLK = 2,
  parameter int SAMP_W       = 32
);
  logic                           tvalid;
  logic                           tready;
  logic                           tlast;
  logic [0:0]                     tuser;
  logic [SAMP_PER_CLK*SAMP_W-1:0] tdata;

  modport master (
    output tvalid, tdata, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/adc_capture_seq.sv
// Capture sequencer: gates the ADC, drops settle beats, forwards N frames.
// Build option ADC_CAPTURE_CONTINUOUS_EN: num_frames==0 runs until abort.
module adc_capture_seq #(
  parameter int SAMP_PER_CLK = 2,
  parameter int FRAME_LEN    = 64,
  parameter int CNT_W        = 16,
  parameter int SAMP_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_frames,
  input  logic [CNT_W-1:0] settle_beats,
  output logic             adc_en,
  adc_capture_seq_if.slave  s_axis,
  adc_capture_seq_if.master m_axis,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             overflow
);

  localparam int BEATS = FRAME_LEN / SAMP_PER_CLK;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = SAMP_PER_CLK * SAMP_W;

`ifdef ADC_CAPTURE_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE, SETTLE, CAPTURE, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] nfr_q, nfr_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             first_q, first_d;
  logic             ovf_q, ovf_d;
  logic             en_q, en_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             user_q, user_d;
  logic [DW-1:0]    data_q, data_d;

  logic room;
  logic start;
  logic zero_arm;
  logic nfr_zero;
  logic at_last;
  logic unused_in;

  assign s_axis.tready = 1'b1;
  assign unused_in = ^{s_axis.tuser, s_axis.tlast};

  // output slot is free, or frees up on this same edge
  assign room     = !vld_q || m_axis.tready;
  assign start    = arm && !abort &&
                    (state_q == IDLE || state_q == DONE);
  assign zero_arm = (num_frames == '0) && !CONT;
  assign nfr_zero = (nfr_q == '0);
  assign at_last  = (beat_q == BW'(BEATS - 1));

  always_comb begin
    state_d  = state_q;
    nfr_d    = nfr_q;
    settle_d = settle_q;
    fcnt_d   = fcnt_q;
    beat_d   = beat_q;
    first_d  = first_q;
    ovf_d    = ovf_q;
    vld_d    = vld_q;
    last_d   = last_q;
    user_d   = user_q;
    data_d   = data_q;

    if (vld_q && m_axis.tready) vld_d = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else if (start) begin
      nfr_d    = num_frames;
      settle_d = settle_beats;
      fcnt_d   = '0;
      ovf_d    = 1'b0;
      beat_d   = '0;
      first_d  = 1'b1;
      if (zero_arm || settle_beats == '0)
        state_d = CAPTURE;
      else
        state_d = SETTLE;
    end else begin
      unique case (state_q)
        SETTLE: begin
          if (s_axis.tvalid) begin
            settle_d = settle_q - CNT_W'(1);
            if (settle_q == CNT_W'(1))
              state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (nfr_zero && !CONT) begin
            state_d = DONE;
          end else if (s_axis.tvalid) begin
            if (room) begin
              vld_d   = 1'b1;
              data_d  = s_axis.tdata;
              user_d  = first_q;
              last_d  = at_last;
              first_d = 1'b0;
              if (at_last) begin
                beat_d = '0;
                fcnt_d = fcnt_q + CNT_W'(1);
                if (!nfr_zero && fcnt_d == nfr_q)
                  state_d = DONE;
              end else begin
                beat_d = beat_q + BW'(1);
              end
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    en_d = (state_d == SETTLE || state_d == CAPTURE) &&
           !(nfr_d == '0 && !CONT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      nfr_q    <= '0;
      settle_q <= '0;
      fcnt_q   <= '0;
      beat_q   <= '0;
      first_q  <= 1'b0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      user_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      nfr_q    <= nfr_d;
      settle_q <= settle_d;
      fcnt_q   <= fcnt_d;
      beat_q   <= beat_d;
      first_q  <= first_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
      user_q   <= user_d;
      data_q   <= data_d;
    end
  end

  assign adc_en          = en_q;
  assign busy            = (state_q == SETTLE) ||
                           (state_q == CAPTURE);
  assign done            = (state_q == DONE);
  assign frame_cnt       = fcnt_q;
  assign overflow        = ovf_q;
  assign m_axis.tvalid   = vld_q;
  assign m_axis.tdata    = data_q;
  assign m_axis.tuser[0] = user_q;
  assign m_axis.tlast    = last_q;

endmodule
